// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-bus responder.
//   DATA_W / INTG_W : default data and integrity widths
//   mem_bus_rsp_t   : one response entry {err, rdata, intg} at default widths
//   mem_bus_intg_w  : width-generic integrity fold (bit i = XOR of data[j], j mod intg_w == i)
//   mem_bus_intg    : integrity at the default widths
package mem_bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned INTG_W = 7;

    // Upper bounds for the width-generic helper; callers zero-extend into these.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_INTG_W = 32;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
        logic [INTG_W-1:0] intg;
    } mem_bus_rsp_t;

    // Fold the data word in intg_w-wide chunks; XOR of chunk k places data[k*intg_w + i]
    // on bit i, which is exactly the "j mod intg_w" grouping. Zero padding folds to 0.
    function automatic logic [MAX_INTG_W-1:0] mem_bus_intg_w(
        input logic [MAX_DATA_W-1:0] data,
        input int unsigned           intg_w
    );
        logic [MAX_INTG_W-1:0] acc;
        logic [MAX_INTG_W-1:0] mask;
        acc  = '0;
        mask = MAX_INTG_W'((64'd1 << intg_w) - 64'd1);
        for (int unsigned k = 0; k < MAX_DATA_W; k++) begin
            if (k * intg_w < MAX_DATA_W) begin
                acc = acc ^ (MAX_INTG_W'(data >> (k * intg_w)) & mask);
            end
        end
        return acc;
    endfunction

    function automatic logic [INTG_W-1:0] mem_bus_intg(input logic [DATA_W-1:0] data);
        logic [MAX_INTG_W-1:0] full;
        full = mem_bus_intg_w(MAX_DATA_W'(data), INTG_W);
        return full[INTG_W-1:0];
    endfunction

endpackage

// File: rtl/mem_bus_rsp_fifo.sv
// In-order response FIFO with synchronous active-low reset.
//   clk, rst        : clock, synchronous active-low reset
//   push_i, wdata_i : enqueue one entry
//   pop_i           : dequeue the head (ignored when empty)
//   rdata_o         : head entry, combinational
//   full_o, empty_o : occupancy flags
module mem_bus_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCnt);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    // The owner's outstanding counter must keep pushes from ever hitting a full FIFO.
    assert property (@(posedge clk) disable iff (!rst) !(push_i && full_o));

endmodule

// File: rtl/mem_bus_resp.sv
// Memory-bus responder (req/gnt/rvalid slave) in front of a 1-cycle-latency SRAM.
//   clk, rst               : clock, synchronous active-low reset
//   data_*                 : core data-port slave side (request, grant, in-order responses)
//   sram_*                 : single-port SRAM master side; rdata valid the cycle after req
//   gnt_stall_i            : force grant low
//   rsp_stall_i            : hold responses in the queue
//   outstanding_o          : accepted requests not yet responded
module mem_bus_resp
    import mem_bus_pkg::*;
#(
    parameter int unsigned       DATA_W     = mem_bus_pkg::DATA_W,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INTG_W     = mem_bus_pkg::INTG_W,
    parameter int unsigned       MEM_WORDS  = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned       DEPTH      = 4,
    parameter bit                CHECK_INTG = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           data_req_i,
    output logic                           data_gnt_o,
    output logic                           data_rvalid_o,
    input  logic                           data_we_i,
    input  logic [DATA_W/8-1:0]            data_be_i,
    input  logic [ADDR_W-1:0]              data_addr_i,
    input  logic [DATA_W-1:0]              data_wdata_i,
    input  logic [INTG_W-1:0]              data_wdata_intg_i,
    output logic [DATA_W-1:0]              data_rdata_o,
    output logic [INTG_W-1:0]              data_rdata_intg_o,
    output logic                           data_err_o,
    output logic                           sram_req_o,
    output logic                           sram_we_o,
    output logic [DATA_W/8-1:0]            sram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]              sram_wdata_o,
    input  logic [DATA_W-1:0]              sram_rdata_i,
    input  logic                           gnt_stall_i,
    input  logic                           rsp_stall_i,
    output logic [$clog2(DEPTH+1)-1:0]     outstanding_o
);

    localparam int unsigned SramAw = $clog2(MEM_WORDS);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned RspW   = 1 + DATA_W + INTG_W;
    localparam logic [CntW-1:0]   CntMax   = CntW'(DEPTH);
    localparam logic [ADDR_W:0]   WinBytes = (ADDR_W + 1)'(4 * MEM_WORDS);

    function automatic logic [INTG_W-1:0] intg_of(input logic [DATA_W-1:0] d);
        logic [MAX_INTG_W-1:0] full;
        full = mem_bus_intg_w(MAX_DATA_W'(d), INTG_W);
        return full[INTG_W-1:0];
    endfunction

    // Request decode
    logic              accept;
    logic [ADDR_W-1:0] offset;
    logic              in_window;
    logic              addr_err;
    logic              intg_err;
    logic              req_err;

    // Pipe stage between SRAM access and FIFO push
    logic p_valid_q, p_valid_d;
    logic p_we_q, p_we_d;
    logic p_err_q, p_err_d;

    // Response path
    logic [DATA_W-1:0] push_rdata;
    logic [RspW-1:0]   push_entry;
    logic [RspW-1:0]   head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rsp_valid;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Grant depends only on state so the LSU can decide on req without a comb loop.
    assign data_gnt_o = rst && !gnt_stall_i && (cnt_q < CntMax);
    assign accept     = data_req_i && data_gnt_o;

    // Offset check also covers addresses below the base, which wrap to large offsets.
    assign offset    = data_addr_i - BASE_ADDR;
    assign in_window = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < WinBytes);
    assign addr_err  = !in_window || (data_addr_i[1:0] != 2'b00);
    assign intg_err  = CHECK_INTG && data_we_i && (data_wdata_intg_i != intg_of(data_wdata_i));
    assign req_err   = addr_err || intg_err;

    assign sram_req_o   = accept && !req_err;
    assign sram_we_o    = data_we_i;
    assign sram_be_o    = data_be_i;
    assign sram_addr_o  = offset[2 +: SramAw];
    assign sram_wdata_o = data_wdata_i;

    always_comb begin
        p_valid_d = accept;
        p_we_d    = data_we_i;
        p_err_d   = req_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_valid_q <= 1'b0;
            p_we_q    <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_we_q    <= p_we_d;
            p_err_q   <= p_err_d;
        end
    end

    // Only an error-free read returns SRAM data; writes and errors respond with zero.
    assign push_rdata = (!p_we_q && !p_err_q) ? sram_rdata_i : '0;
    assign push_entry = {p_err_q, push_rdata, intg_of(push_rdata)};

    mem_bus_rsp_fifo #(
        .WIDTH (RspW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (p_valid_q),
        .wdata_i (push_entry),
        .pop_i   (rsp_valid),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_valid         = rst && !fifo_empty && !rsp_stall_i;
    assign data_rvalid_o     = rsp_valid;
    assign data_err_o        = head_entry[RspW-1];
    assign data_rdata_o      = head_entry[INTG_W +: DATA_W];
    assign data_rdata_intg_o = head_entry[INTG_W-1:0];

    // Counts pipe + FIFO occupancy, which is what bounds the grant.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, rsp_valid})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/mem_bus_resp.md
Name: mem_bus_resp

Overview:
- Parametrised memory-bus responder (slave side of the core data port: req/gnt/rvalid, be, integrity) fronting a single-port, 1-cycle-latency SRAM.
- Generalises the data-port protocol with configurable data width, outstanding-request depth, address window, error signalling, write-integrity checking, and grant/response stall modes.
- Sits between the core LSU and the data SRAM in the SoC. It is also usable as a synthesizable reference slave in the bus agent's environment.

Parameters:
- DATA_W, 32: data width; must be a multiple of 8.
- ADDR_W, 32: byte-address width.
- INTG_W, 7: integrity width.
- MEM_WORDS, 1024: SRAM depth in words.
- BASE_ADDR, 32'h0001_0000: window base; must be word-aligned.
- DEPTH, 4: maximum outstanding requests (≥1).
- CHECK_INTG, 1: 1 = check write integrity; 0 = ignore data_wdata_intg_i.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- data_req_i  in  1  request
- data_gnt_o  out  1  grant
- data_rvalid_o  out  1  response valid
- data_we_i  in  1  1 = write
- data_be_i  in  DATA_W/8  byte enables
- data_addr_i  in  ADDR_W  byte address
- data_wdata_i  in  DATA_W  write data
- data_wdata_intg_i  in  INTG_W  write integrity
- data_rdata_o  out  DATA_W  read data
- data_rdata_intg_o  out  INTG_W  read-data integrity
- data_err_o  out  1  error; qualified by rvalid
- sram_req_o  out  1  SRAM access
- sram_we_o  out  1  SRAM write
- sram_be_o  out  DATA_W/8  SRAM byte enables
- sram_addr_o  out  $clog2(MEM_WORDS)  SRAM word index
- sram_wdata_o  out  DATA_W  SRAM write data
- sram_rdata_i  in  DATA_W  SRAM read data; valid the cycle after sram_req_o
- gnt_stall_i  in  1  force data_gnt_o low
- rsp_stall_i  in  1  hold responses in the queue
- outstanding_o  out  $clog2(DEPTH+1)  accepted requests not yet responded

Behaviour:
- Reset: rst low at a clock edge clears the pipe stage, the FIFO and the counter. While rst is low, data_gnt_o = data_rvalid_o = sram_req_o = 0. All registered outputs reset to 0. In-flight requests are dropped and produce no response.
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Grant: data_gnt_o = rst && !gnt_stall_i && (cnt < DEPTH).
  - Combinational from state; does not depend on data_req_i.
  - Accept = data_req_i && data_gnt_o in cycle N.
- Error conditions, evaluated at accept:
  - addr_err: data_addr_i outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS), or addr[1:0] != 0.
  - intg_err: CHECK_INTG && we && (data_wdata_intg_i != intg(data_wdata_i)).
  - err = addr_err || intg_err.
- SRAM drive, combinational in cycle N:
  - sram_req_o = accept && !err.
  - sram_addr_o = (addr − BASE_ADDR) >> 2; sram_we_o / sram_be_o / sram_wdata_o pass through.
  - An erroneous write never reaches the SRAM.
- Pipe stage: on accept, register {we, err} into p_valid.
- Cycle N+1: push {err, rdata, intg(rdata)} into the FIFO.
  - rdata = sram_rdata_i for an error-free read, else 0.
  - intg(x): bit i = XOR of x[j] over all j with j mod INTG_W == i.
- Response (FIFO: DEPTH entries, in order):
  - data_rvalid_o = !empty && !rsp_stall_i. It, data_rdata_o, data_rdata_intg_o and data_err_o are combinational from the FIFO head.
  - Pop when data_rvalid_o.
  - Minimum latency: accept in N → rvalid in N+2.
  - Back-to-back accepts give one rvalid per cycle.
- Counter:
  - cnt +1 on accept, −1 on rvalid; unchanged on simultaneous accept and rvalid.
  - cnt covers pipe + FIFO entries, so the FIFO cannot overflow. Push while full is an assertion failure.
  - outstanding_o = cnt.
- Boundaries:
  - cnt == DEPTH: gnt low; a same-cycle rvalid does not re-raise gnt until the next cycle.
  - rsp_stall_i held: cnt saturates at DEPTH and gnt stays low.
  - Last window word (BASE + 4*MEM_WORDS − 4) is legal; the next word is an error.
  - SRAM index wraps never, because out-of-range addresses are errored.

Decomposition:
- mem_bus_pkg holds:
  - mem_bus_rsp_t struct {err, rdata, intg};
  - function mem_bus_intg(data) → INTG_W;
  - default constants DATA_W, INTG_W.
- Sub-module mem_bus_rsp_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop, full/empty, and the same synchronous active-low reset.

Test Plan:
- Write 0xDEADBEEF, be=4'hF, correct intg, at BASE+0x10, then read the same address → sram_addr_o=4 on both; read rvalid at N+2 with rdata=0xDEADBEEF, intg=mem_bus_intg(0xDEADBEEF), err=0.
- Read at BASE+4*MEM_WORDS and at BASE+0x2 → no sram_req_o; rvalid at N+2 with err=1, rdata=0.
- Write with flipped intg bit 0, CHECK_INTG=1 → sram_req_o=0, err=1; a follow-up read returns the old data.
- rsp_stall_i=1, req held high with DEPTH=4 → exactly 4 grants, then gnt=0, outstanding_o=4; release stall → 4 in-order rvalids on consecutive cycles, gnt returns the cycle after the first pop.
- 8 back-to-back reads, no stalls → gnt constant 1, rvalid every cycle from N+2, data in order.
- Drop rst low with 3 requests outstanding → next cycle rvalid=0, outstanding_o=0, gnt=0 while reset is held; after release, the first read behaves normally.
